// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus generator / arbiter.
// Holds the ID field width, the lane FSM states and the ID extractor.
package bus_pkg;

    localparam int ID_W    = 8;
    localparam int MAX_PKT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_t;

    // Destination ID sits in the top ID_W bits of a w-bit packet.
    function automatic logic [ID_W-1:0] dest_id(
        input logic [MAX_PKT-1:0] p,
        input int                 w
    );
        return p[w-1 -: ID_W];
    endfunction

endpackage

// File: rtl/bus_arb_lane.sv
// One bus: round-robin grant, pop from the granted device,
// then push the packet to its destination(s).
module bus_arb_lane
    import bus_pkg::*;
#(
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [drvrs-1:0]                 pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]    D_pop,
    output logic [drvrs-1:0]                 pop,
    output logic [drvrs-1:0]                 push,
    output logic [drvrs-1:0][pckg_sz-1:0]    D_push
);

    localparam int GW = (drvrs > 1) ? $clog2(drvrs) : 1;

    state_t             state;
    logic [GW-1:0]      rr_ptr;
    logic [GW-1:0]      gnt;
    logic [GW-1:0]      nxt;
    logic               found;
    logic [pckg_sz-1:0] pkt;
    logic [ID_W-1:0]    id;
    logic [drvrs-1:0]   dst;

    // First pending device at or after rr_ptr, wrapping around.
    always_comb begin
        int idx;
        idx   = 0;
        nxt   = '0;
        found = 1'b0;
        for (int i = 0; i < drvrs; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= drvrs) idx = idx - drvrs;
            if (!found && pndng[idx]) begin
                found = 1'b1;
                nxt   = GW'(idx);
            end
        end
    end

    // Destination set for the granted device's head packet.
    always_comb begin
        id  = dest_id(MAX_PKT'(D_pop[gnt]), pckg_sz);
        dst = '0;
        for (int i = 0; i < drvrs; i++) begin
            if (id == broadcast)
                dst[i] = (GW'(i) != gnt);
            else
                dst[i] = (int'(id) == i);
        end
    end

    // Lane FSM; all strobes and the packet register are registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            gnt    <= '0;
            pkt    <= '0;
            pop    <= '0;
            push   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    push <= '0;
                    pop  <= '0;
                    if (found) begin
                        gnt      <= nxt;
                        pop[nxt] <= 1'b1;
                        state    <= POP;
                    end
                end
                POP: begin
                    pop   <= '0;
                    pkt   <= D_pop[gnt];
                    push  <= dst;
                    state <= PUSH;
                end
                PUSH: begin
                    push   <= '0;
                    rr_ptr <= (gnt == GW'(drvrs - 1)) ? '0 : GW'(gnt + 1'b1);
                    state  <= IDLE;
                end
                default: begin
                    pop   <= '0;
                    push  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Every device sees the captured packet; only push qualifies it.
    always_comb begin
        for (int i = 0; i < drvrs; i++) D_push[i] = pkt;
    end

endmodule

// File: rtl/bus_generator_n_arbiter.sv
// Shared-bus generator and arbiter: one independent lane per bus.
// Each lane moves one packet per grant from a device FIFO to its target(s).
module bus_generator_n_arbiter
    import bus_pkg::*;
#(
    parameter int              bits      = 1,
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [bits-1:0][drvrs-1:0]               pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_pop,
    output logic [bits-1:0][drvrs-1:0]               pop,
    output logic [bits-1:0][drvrs-1:0]               push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_push
);

    for (genvar b = 0; b < bits; b++) begin : g_bus
        bus_arb_lane #(
            .drvrs     (drvrs),
            .pckg_sz   (pckg_sz),
            .broadcast (broadcast)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .pndng  (pndng[b]),
            .D_pop  (D_pop[b]),
            .pop    (pop[b]),
            .push   (push[b]),
            .D_push (D_push[b])
        );
    end

endmodule

// File: tb/tb_bus_generator_n_arbiter.sv
// Directed bench for bus_generator_n_arbiter with an expectation queue.
// Transactions are queued when driven and checked when pop/push appear.
module tb_bus_generator_n_arbiter;

    localparam int B = 1;
    localparam int N = 4;
    localparam int W = 16;

    typedef struct {
        string       tag;
        logic [3:0]  popv;
        logic [3:0]  pushv;
        logic [15:0] data;
    } exp_t;

    logic                       clk_tb = 1'b0;
    logic                       reset;
    logic [B-1:0][N-1:0]        pndng;
    logic [B-1:0][N-1:0][W-1:0] d_pop;
    logic [B-1:0][N-1:0]        pop;
    logic [B-1:0][N-1:0]        push;
    logic [B-1:0][N-1:0][W-1:0] d_push;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk_tb = ~clk_tb;

    bus_generator_n_arbiter #(
        .bits      (B),
        .drvrs     (N),
        .pckg_sz   (W),
        .broadcast (8'hFF)
    ) dut (
        .clk    (clk_tb),
        .reset  (reset),
        .pndng  (pndng),
        .D_pop  (d_pop),
        .pop    (pop),
        .push   (push),
        .D_push (d_push)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic enq(string tag, logic [3:0] pv, logic [3:0] sv, logic [15:0] d);
        exp_t e;
        e.tag   = tag;
        e.popv  = pv;
        e.pushv = sv;
        e.data  = d;
        sbq.push_back(e);
    endtask

    // Waits for the next pop, checks it and the following push cycle.
    task automatic take(bit drop);
        exp_t e;
        int   cyc;
        e   = sbq.pop_front();
        cyc = 0;
        do begin
            @(negedge clk_tb);
            cyc++;
        end while (pop[0] == '0 && cyc < 8);
        chk({e.tag, "_lat"}, cyc, 1);
        chk({e.tag, "_pop"}, pop[0], e.popv);
        chk({e.tag, "_push_in_pop"}, push[0], 4'b0);
        if (drop) pndng[0] = pndng[0] & ~e.popv;
        @(negedge clk_tb);
        chk({e.tag, "_push"}, push[0], e.pushv);
        chk({e.tag, "_pop_in_push"}, pop[0], 4'b0);
        for (int i = 0; i < N; i++)
            chk({e.tag, "_dpush"}, d_push[0][i], e.data);
        @(negedge clk_tb);
        chk({e.tag, "_push_off"}, push[0], 4'b0);
    endtask

    initial begin
        reset = 1'b0;
        pndng = '0;
        d_pop = '0;

        // 1. reset held with random requests
        for (int k = 0; k < 6; k++) begin
            pndng[0] = 4'($urandom_range(1, 15));
            @(negedge clk_tb);
            chk("rst_pop", pop, 4'b0);
            chk("rst_push", push, 4'b0);
            chk("rst_dpush", d_push, 64'b0);
        end
        pndng = '0;
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk_tb);
            chk("idle_pop", pop, 4'b0);
            chk("idle_push", push, 4'b0);
        end

        // 2. unicast 1 -> 2
        d_pop[0][1] = 16'h02AB;
        pndng[0]    = 4'b0010;
        enq("uni", 4'b0010, 4'b0100, 16'h02AB);
        take(1'b1);

        // 3. broadcast from 0
        d_pop[0][0] = 16'hFF55;
        pndng[0]    = 4'b0001;
        enq("bcast", 4'b0001, 4'b1110, 16'hFF55);
        take(1'b1);

        // 5. invalid destination from 3
        d_pop[0][3] = 16'h07C3;
        pndng[0]    = 4'b1000;
        enq("inval", 4'b1000, 4'b0000, 16'h07C3);
        take(1'b1);

        // self-address goes back to the source
        d_pop[0][2] = 16'h0211;
        pndng[0]    = 4'b0100;
        enq("self", 4'b0100, 4'b0100, 16'h0211);
        take(1'b1);

        // 4. round-robin from a fresh reset, all requesting
        reset = 1'b0;
        @(negedge clk_tb);
        reset = 1'b1;
        for (int i = 0; i < N; i++)
            d_pop[0][i] = {8'((i + 1) % N), 8'(8'h10 + i)};
        pndng[0] = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int s;
            s = k % N;
            enq($sformatf("rr%0d", k), 4'(1 << s), 4'(1 << ((s + 1) % N)),
                {8'((s + 1) % N), 8'(8'h10 + s)});
        end
        for (int k = 0; k < 5; k++) take(1'b0);
        pndng = '0;
        repeat (3) @(negedge clk_tb);

        // 6. reset during PUSH, then device 0 first
        d_pop[0][2] = 16'h0399;
        pndng[0]    = 4'b0100;
        @(negedge clk_tb);
        chk("rp_pop", pop[0], 4'b0100);
        pndng = '0;
        @(negedge clk_tb);
        chk("rp_push", push[0], 4'b1000);
        #1 reset = 1'b0;
        #1;
        chk("rp_push_clr", push[0], 4'b0);
        chk("rp_dpush_clr", d_push, 64'b0);
        @(negedge clk_tb);
        reset = 1'b1;
        for (int i = 0; i < N; i++)
            d_pop[0][i] = {8'((i + 1) % N), 8'(8'h20 + i)};
        pndng[0] = 4'b1111;
        enq("post_rst", 4'b0001, 4'b0010, 16'h0120);
        take(1'b0);
        pndng = '0;
        repeat (4) @(negedge clk_tb);
        chk("end_pop", pop, 4'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
